// File: rtl/relu_result_writeback_if.sv
// Buffer write port carried from relu_result_writeback to the result buffer.
// A word moves when wr_valid and wr_ready are both high on a rising clock edge.
interface relu_result_writeback_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/relu_result_writeback.sv
// relu_result_writeback: captures a finished relu vector and its lane mask on
// done_in, then drains the active lanes in ascending order into the buffer
// write port, one word per handshake, and ends with a one-cycle wb_done.
// A done_in that arrives while a vector is still being drained is dropped
// and latches the sticky overflow flag.
// Optional build macro: WB_ZERO_SKIP_EN -- lanes whose captured value is
// exactly zero are removed from the drain set, so zeros are never written.
module relu_result_writeback #(
  parameter int WIDTH      = 16,
  parameter int NUM_UNITS  = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       done_in,
  input  logic [NUM_UNITS*WIDTH-1:0] relu_in,
  input  logic [NUM_UNITS-1:0]       active_in,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  relu_result_writeback_if.master    wr_bus,
  output logic                       busy,
  output logic                       wb_done,
  output logic                       overflow
);

  localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FIN
  } state_t;

  state_t                     state;
  logic [NUM_UNITS*WIDTH-1:0] data_q;
  logic [NUM_UNITS-1:0]       pend_q;
  logic [ADDR_WIDTH-1:0]      base_q;
  logic [SEL_W-1:0]           sel_q;

  logic                       wr_valid_q;
  logic [ADDR_WIDTH-1:0]      wr_addr_q;
  logic [WIDTH-1:0]           wr_data_q;

  logic [NUM_UNITS-1:0]       capture_mask;
  logic [NUM_UNITS-1:0]       pend_after;
  logic [SEL_W-1:0]           head_sel;
  logic [SEL_W-1:0]           next_sel;

  // Index of the lowest set bit; returns 0 for an empty mask (callers check
  // for an empty mask separately).
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_UNITS-1:0] mask);
    lowest_set = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = SEL_W'(i);
    end
  endfunction

  // Lane set taken at capture time; with zero skipping, zero-valued lanes drop out.
  always_comb begin
    capture_mask = active_in;
`ifdef WB_ZERO_SKIP_EN
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (relu_in[i*WIDTH +: WIDTH] == '0) capture_mask[i] = 1'b0;
    end
`endif
  end

  // Lane to present on entry to the drain, and the lane that follows a handshake.
  always_comb begin
    pend_after        = pend_q;
    pend_after[sel_q] = 1'b0;
    head_sel          = lowest_set(pend_q);
    next_sel          = lowest_set(pend_after);
  end

  // Capture/drain/finish sequencer with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      data_q     <= '0;
      pend_q     <= '0;
      base_q     <= '0;
      sel_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy       <= 1'b0;
      wb_done    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wb_done <= 1'b0;
      if (done_in && state != IDLE) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (done_in) begin
            data_q <= relu_in;
            pend_q <= capture_mask;
            base_q <= base_addr;
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end

        SCAN: begin
          if (!wr_valid_q) begin
            if (pend_q == '0) begin
              busy    <= 1'b0;
              wb_done <= 1'b1;
              state   <= FIN;
            end else begin
              sel_q      <= head_sel;
              wr_valid_q <= 1'b1;
              wr_addr_q  <= base_q + ADDR_WIDTH'(head_sel);
              wr_data_q  <= data_q[head_sel*WIDTH +: WIDTH];
            end
          end else if (wr_bus.wr_ready) begin
            pend_q <= pend_after;
            if (pend_after == '0) begin
              wr_valid_q <= 1'b0;
              busy       <= 1'b0;
              wb_done    <= 1'b1;
              state      <= FIN;
            end else begin
              sel_q     <= next_sel;
              wr_addr_q <= base_q + ADDR_WIDTH'(next_sel);
              wr_data_q <= data_q[next_sel*WIDTH +: WIDTH];
            end
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign wr_bus.wr_valid = wr_valid_q;
  assign wr_bus.wr_addr  = wr_addr_q;
  assign wr_bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_relu_result_writeback.sv
// Directed bench for relu_result_writeback: full drain, stalled sparse drain,
// empty capture, address wrap, overflow, reset mid-drain and zero skipping.
module tb_relu_result_writeback;

  localparam int WIDTH      = 16;
  localparam int NUM_UNITS  = 16;
  localparam int ADDR_WIDTH = 10;

  logic                       clk;
  logic                       reset;
  logic                       done_in;
  logic [NUM_UNITS*WIDTH-1:0] relu_in;
  logic [NUM_UNITS-1:0]       active_in;
  logic [ADDR_WIDTH-1:0]      base_addr;
  logic                       busy;
  logic                       wb_done;
  logic                       overflow;

  int errors;
  int checks;
  int hs_count;
  int hs_start;

  logic [NUM_UNITS*WIDTH-1:0] vec_a;
  logic [NUM_UNITS*WIDTH-1:0] vec_b;

  relu_result_writeback_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  relu_result_writeback #(
    .WIDTH(WIDTH),
    .NUM_UNITS(NUM_UNITS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .done_in(done_in),
    .relu_in(relu_in),
    .active_in(active_in),
    .base_addr(base_addr),
    .wr_bus(bus.master),
    .busy(busy),
    .wb_done(wb_done),
    .overflow(overflow)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every completed handshake on the write port.
  always @(posedge clk) begin
    if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) hs_count = hs_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic done, input logic [NUM_UNITS*WIDTH-1:0] relu,
                               input logic [NUM_UNITS-1:0] active, input logic [ADDR_WIDTH-1:0] base);
    done_in   = done;
    relu_in   = relu;
    active_in = active;
    base_addr = base;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected)
    else begin
      errors = errors + 1;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input string tag, input logic [31:0] addr, input logic [31:0] data);
    checkOutput({tag, " wr_valid"}, 32'(bus.wr_valid), 32'd1);
    checkOutput({tag, " wr_addr"}, 32'(bus.wr_addr), addr);
    checkOutput({tag, " wr_data"}, 32'(bus.wr_data), data);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    hs_count    = 0;
    reset       = 1'b1;
    bus.wr_ready = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    $display("[TB] reset values");
    checkOutput("rst wr_valid", 32'(bus.wr_valid), 32'd0);
    checkOutput("rst wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("rst wr_data", 32'(bus.wr_data), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst wb_done", 32'(wb_done), 32'd0);
    checkOutput("rst overflow", 32'(overflow), 32'd0);

    // Full 16-lane drain, ready always high
    $display("[TB] full drain");
    for (int i = 0; i < NUM_UNITS; i++) vec_a[i*WIDTH +: WIDTH] = 16'(i + 1);
    bus.wr_ready = 1'b1;
    hs_start = hs_count;
    applyStimulus(1'b1, vec_a, 16'hFFFF, 10'h100);
    tick();
    done_in = 1'b0;
    checkOutput("t1 busy after capture", 32'(busy), 32'd1);
    checkOutput("t1 no valid yet", 32'(bus.wr_valid), 32'd0);
    tick();
    for (int i = 0; i < NUM_UNITS; i++) begin
      checkWrite($sformatf("t1 lane%0d", i), 32'h100 + 32'(i), 32'(i + 1));
      checkOutput("t1 no early wb_done", 32'(wb_done), 32'd0);
      tick();
    end
    checkOutput("t1 wb_done", 32'(wb_done), 32'd1);
    checkOutput("t1 valid low at done", 32'(bus.wr_valid), 32'd0);
    checkOutput("t1 busy low at done", 32'(busy), 32'd0);
    tick();
    checkOutput("t1 wb_done single", 32'(wb_done), 32'd0);
    checkOutput("t1 handshakes", 32'(hs_count - hs_start), 32'd16);

    // Sparse mask with stalls: lanes 0, 2, 15
    $display("[TB] sparse drain with stalls");
    for (int i = 0; i < NUM_UNITS; i++) vec_b[i*WIDTH +: WIDTH] = 16'h1000 + 16'(i);
    hs_start = hs_count;
    applyStimulus(1'b1, vec_b, 16'h8005, 10'h020);
    tick();
    done_in = 1'b0;
    tick();
    bus.wr_ready = 1'b1;
    checkWrite("t2 lane0", 32'h020, 32'h1000);
    tick();
    bus.wr_ready = 1'b0;
    checkWrite("t2 lane2", 32'h022, 32'h1002);
    tick();
    bus.wr_ready = 1'b1;
    checkWrite("t2 lane2 held", 32'h022, 32'h1002);
    tick();
    bus.wr_ready = 1'b0;
    checkWrite("t2 lane15", 32'h02F, 32'h100F);
    tick();
    bus.wr_ready = 1'b1;
    checkWrite("t2 lane15 held", 32'h02F, 32'h100F);
    tick();
    checkOutput("t2 wb_done", 32'(wb_done), 32'd1);
    checkOutput("t2 valid low", 32'(bus.wr_valid), 32'd0);
    checkOutput("t2 handshakes", 32'(hs_count - hs_start), 32'd3);
    tick();

    // Empty mask: no writes, wb_done two cycles after done_in
    $display("[TB] empty mask");
    hs_start = hs_count;
    applyStimulus(1'b1, vec_a, 16'h0000, 10'h155);
    tick();
    done_in = 1'b0;
    checkOutput("t3 busy", 32'(busy), 32'd1);
    checkOutput("t3 wb_done early", 32'(wb_done), 32'd0);
    tick();
    checkOutput("t3 wb_done", 32'(wb_done), 32'd1);
    checkOutput("t3 no valid", 32'(bus.wr_valid), 32'd0);
    checkOutput("t3 busy low", 32'(busy), 32'd0);
    tick();
    checkOutput("t3 wb_done single", 32'(wb_done), 32'd0);
    checkOutput("t3 handshakes", 32'(hs_count - hs_start), 32'd0);

    // Address wrap at the top of the buffer
    $display("[TB] address wrap");
    for (int i = 0; i < NUM_UNITS; i++) vec_b[i*WIDTH +: WIDTH] = 16'h00A0 + 16'(i);
    applyStimulus(1'b1, vec_b, 16'h000F, 10'h3FE);
    tick();
    done_in = 1'b0;
    tick();
    checkWrite("t4 lane0", 32'h3FE, 32'h00A0);
    tick();
    checkWrite("t4 lane1", 32'h3FF, 32'h00A1);
    tick();
    checkWrite("t4 lane2", 32'h000, 32'h00A2);
    tick();
    checkWrite("t4 lane3", 32'h001, 32'h00A3);
    tick();
    checkOutput("t4 wb_done", 32'(wb_done), 32'd1);
    tick();

    // Overflow: second done_in while draining is ignored and sticky
    $display("[TB] overflow");
    for (int i = 0; i < NUM_UNITS; i++) vec_b[i*WIDTH +: WIDTH] = 16'h5500 + 16'(i);
    bus.wr_ready = 1'b0;
    applyStimulus(1'b1, vec_a, 16'h0003, 10'h040);
    tick();
    done_in = 1'b0;
    tick();
    checkOutput("t5 overflow clear", 32'(overflow), 32'd0);
    applyStimulus(1'b1, vec_b, 16'hFFFF, 10'h200);
    tick();
    done_in = 1'b0;
    checkOutput("t5 overflow set", 32'(overflow), 32'd1);
    checkWrite("t5 lane0 kept", 32'h040, 32'd1);
    bus.wr_ready = 1'b1;
    tick();
    checkWrite("t5 lane1 kept", 32'h041, 32'd2);
    tick();
    checkOutput("t5 wb_done", 32'(wb_done), 32'd1);
    checkOutput("t5 overflow sticky", 32'(overflow), 32'd1);
    tick();
    tick();
    checkOutput("t5 second vector dropped", 32'(bus.wr_valid), 32'd0);
    checkOutput("t5 overflow still", 32'(overflow), 32'd1);

    // Reset mid-drain: write drops, no wb_done, overflow cleared
    $display("[TB] reset mid-drain");
    applyStimulus(1'b1, vec_a, 16'hFFFF, 10'h000);
    tick();
    done_in = 1'b0;
    tick();
    tick();
    checkWrite("t5r lane1", 32'h001, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t5r valid dropped", 32'(bus.wr_valid), 32'd0);
    checkOutput("t5r busy dropped", 32'(busy), 32'd0);
    checkOutput("t5r overflow cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t5r no wb_done %0d", i), 32'(wb_done), 32'd0);
      checkOutput($sformatf("t5r no valid %0d", i), 32'(bus.wr_valid), 32'd0);
    end

    // Zero lanes: skipped only when zero skipping is built in
    $display("[TB] zero lanes");
    vec_b = '0;
    vec_b[0*WIDTH +: WIDTH] = 16'h0011;
    vec_b[2*WIDTH +: WIDTH] = 16'h0033;
    hs_start = hs_count;
    applyStimulus(1'b1, vec_b, 16'h000F, 10'h050);
    tick();
    done_in = 1'b0;
    tick();
`ifdef WB_ZERO_SKIP_EN
    checkWrite("t6 lane0", 32'h050, 32'h0011);
    tick();
    checkWrite("t6 lane2", 32'h052, 32'h0033);
    tick();
    checkOutput("t6 wb_done", 32'(wb_done), 32'd1);
    checkOutput("t6 handshakes", 32'(hs_count - hs_start), 32'd2);
`else
    checkWrite("t6 lane0", 32'h050, 32'h0011);
    tick();
    checkWrite("t6 lane1", 32'h051, 32'h0000);
    tick();
    checkWrite("t6 lane2", 32'h052, 32'h0033);
    tick();
    checkWrite("t6 lane3", 32'h053, 32'h0000);
    tick();
    checkOutput("t6 wb_done", 32'(wb_done), 32'd1);
    checkOutput("t6 handshakes", 32'(hs_count - hs_start), 32'd4);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
